// File: rtl/seg_disp_pkg.sv
// Shared constants, state encoding and BCD widths for the tri-digit display feeder.
package seg_disp_pkg;

  localparam int BCD_W       = 4;
  localparam int NUM_DIGITS  = 3;
  localparam int INT_DIGITS  = 5;
  localparam int BCD_MAX     = 999;
  localparam int BCD_FIELD_W = BCD_W * INT_DIGITS;

  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
  import seg_disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Correct the digit so that the following left shift carries into the next decade.
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd3_feeder.sv
// Sequential binary-to-3-digit-BCD converter feeding the 74HC595 display driver.
// Build option BCD_OVERFLOW_SAT_EN: saturate the displayed digits to 999 on overflow.
module bin_to_bcd3_feeder
  import seg_disp_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int TRIG_HOLD = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [IN_WIDTH-1:0] bin_i,
  output logic                busy_o,
  output logic [BCD_W-1:0]    num0_o,
  output logic [BCD_W-1:0]    num1_o,
  output logic [BCD_W-1:0]    num2_o,
  output logic                ovf_o,
  output logic                trigger_o
);

  localparam int SR_W   = BCD_FIELD_W + IN_WIDTH;
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);
  localparam int HOLD_W = $clog2(TRIG_HOLD + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(IN_WIDTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TRIG_HOLD - 1);

  state_e              state_q;
  logic [SR_W-1:0]     shift_q;
  logic [SR_W-1:0]     shift_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                busy_q;
  logic                trigger_q;
  logic                ovf_q;
  logic [BCD_W-1:0]    num0_q, num1_q, num2_q;

  logic [BCD_FIELD_W-1:0] bcd_corr_s;
  logic [BCD_FIELD_W-1:0] bcd_res_s;
  logic                   ovf_s;
  logic [BCD_W-1:0]       dig0_s, dig1_s, dig2_s;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i(shift_q[IN_WIDTH + g*BCD_W +: BCD_W]),
      .digit_o(bcd_corr_s[g*BCD_W +: BCD_W])
    );
  end

  // One double-dabble step: corrected BCD field and untouched binary bits shift left together.
  always_comb begin
    shift_d = {bcd_corr_s, shift_q[IN_WIDTH-1:0]} << 1'b1;
  end

  // Final digit selection from the fully shifted BCD field.
  always_comb begin
    bcd_res_s = shift_q[SR_W-1 -: BCD_FIELD_W];
    ovf_s     = |bcd_res_s[BCD_FIELD_W-1 : NUM_DIGITS*BCD_W];
`ifdef BCD_OVERFLOW_SAT_EN
    if (ovf_s) begin
      dig0_s = BCD_NINE;
      dig1_s = BCD_NINE;
      dig2_s = BCD_NINE;
    end else begin
      dig0_s = bcd_res_s[0*BCD_W +: BCD_W];
      dig1_s = bcd_res_s[1*BCD_W +: BCD_W];
      dig2_s = bcd_res_s[2*BCD_W +: BCD_W];
    end
`else
    dig0_s = bcd_res_s[0*BCD_W +: BCD_W];
    dig1_s = bcd_res_s[1*BCD_W +: BCD_W];
    dig2_s = bcd_res_s[2*BCD_W +: BCD_W];
`endif
  end

  // Control FSM with counters and registered outputs; digits change only in LOAD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      trigger_q  <= 1'b0;
      ovf_q      <= 1'b0;
      num0_q     <= 4'd0;
      num1_q     <= 4'd0;
      num2_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q   <= {{BCD_FIELD_W{1'b0}}, bin_i};
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          if (bit_cnt_q == LAST_BIT) begin
            state_q <= LOAD;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        LOAD: begin
          num0_q     <= dig0_s;
          num1_q     <= dig1_s;
          num2_q     <= dig2_s;
          ovf_q      <= ovf_s;
          trigger_q  <= 1'b1;
          hold_cnt_q <= HOLD_LOAD;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt_q == '0) begin
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign trigger_o = trigger_q;
  assign ovf_o     = ovf_q;
  assign num0_o    = num0_q;
  assign num1_o    = num1_q;
  assign num2_o    = num2_q;

endmodule

// File: tb/tb_bin_to_bcd3_feeder.sv
// Randomized self-checking bench for bin_to_bcd3_feeder against an arithmetic reference model.
module tb_bin_to_bcd3_feeder;

  localparam int IN_WIDTH  = 10;
  localparam int TRIG_HOLD = 4;
  localparam int LAT       = IN_WIDTH + 1;
  localparam int BUSY_LEN  = IN_WIDTH + 1 + TRIG_HOLD;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [IN_WIDTH-1:0] bin = '0;
  logic                busy, ovf, trigger;
  logic [3:0]          num0, num1, num2;

  int checks = 0;
  int passes = 0;

  bin_to_bcd3_feeder #(.IN_WIDTH(IN_WIDTH), .TRIG_HOLD(TRIG_HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
    .busy_o(busy), .num0_o(num0), .num1_o(num1), .num2_o(num2),
    .ovf_o(ovf), .trigger_o(trigger)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits by plain arithmetic, packed as {ovf, n2, n1, n0}.
  function automatic logic [12:0] model(input int v);
    int shown;
    logic o;
    o = (v > 999);
    shown = v % 1000;
`ifdef BCD_OVERFLOW_SAT_EN
    if (o) shown = 999;
`endif
    return {o, 4'(shown / 100), 4'((shown / 10) % 10), 4'(shown % 10)};
  endfunction

  function automatic logic [12:0] observed();
    return {ovf, num2, num1, num0};
  endfunction

  // Runs one conversion and reports what was seen; index k = negedge after the k-th edge past acceptance.
  task automatic run_conv(input logic [IN_WIDTH-1:0] v, output logic [12:0] res,
                          output int busy_n, output int trig_n, output int trig_first,
                          output bit early_chg, output bit late_chg);
    logic [12:0] prev, snap;
    prev = observed();
    snap = prev;
    busy_n = 0; trig_n = 0; trig_first = -1; early_chg = 0; late_chg = 0;
    @(posedge clk); #1 start = 1'b1; bin = v;
    @(posedge clk); #1 start = 1'b0; bin = IN_WIDTH'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (trigger) begin
        if (trig_first < 0) begin
          trig_first = k;
          snap = observed();
        end
        trig_n++;
      end
      if (trig_first < 0 && observed() !== prev) early_chg = 1;
      if (trig_first >= 0 && observed() !== snap) late_chg = 1;
      if (!busy) break;
    end
    res = snap;
  endtask

  task automatic test_reset();
    checks++; if ({busy, trigger, ovf} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {busy, trigger, ovf}); else passes++;
    checks++; if ({num2, num1, num0} !== 12'h000) $display("FAIL reset_num: got %h expected 000", {num2, num1, num0}); else passes++;
  endtask

  task automatic test_zero();
    logic [12:0] r; int bn, tn, tf; bit ec, lc;
    run_conv('0, r, bn, tn, tf, ec, lc);
    checks++; if (r !== model(0)) $display("FAIL zero_value: got %h expected %h", r, model(0)); else passes++;
    checks++; if (tf !== LAT) $display("FAIL zero_latency: got %0d expected %0d", tf, LAT); else passes++;
    checks++; if (tn !== TRIG_HOLD) $display("FAIL zero_trig_len: got %0d expected %0d", tn, TRIG_HOLD); else passes++;
    checks++; if (bn !== BUSY_LEN) $display("FAIL zero_busy_len: got %0d expected %0d", bn, BUSY_LEN); else passes++;
  endtask

  task automatic test_corners();
    int vals[5] = '{987, 999, 1000, 1023, 5};
    logic [12:0] r; int bn, tn, tf; bit ec, lc;
    foreach (vals[i]) begin
      run_conv(IN_WIDTH'(vals[i]), r, bn, tn, tf, ec, lc);
      checks++; if (r !== model(vals[i])) $display("FAIL corner_%0d: got %h expected %h", vals[i], r, model(vals[i])); else passes++;
      checks++; if (lc) $display("FAIL corner_stable_%0d: got change after load expected none", vals[i]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [12:0] r, prev; int v, bn, tn, tf; bit ec, lc;
    prev = observed();
    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(IN_WIDTH'(v), r, bn, tn, tf, ec, lc);
      checks++; if (r !== model(v)) $display("FAIL random_%0d: got %h expected %h", v, r, model(v)); else passes++;
      checks++; if (ec || lc) $display("FAIL random_stable_%0d: got early=%0d late=%0d expected 0 0", v, ec, lc); else passes++;
      checks++; if (tf !== LAT || bn !== BUSY_LEN) $display("FAIL random_timing_%0d: got trig@%0d busy=%0d expected %0d %0d", v, tf, bn, LAT, BUSY_LEN); else passes++;
      prev = r;
    end
  endtask

  task automatic test_ignore_start();
    int rises = 0, bn = 0; logic pt = 1'b0;
    @(posedge clk); #1 start = 1'b1; bin = 10'd5;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 3) begin start = 1'b1; bin = 10'd7; end
      if (k == 4) start = 1'b0;
      if (busy) bn++;
      if (trigger && !pt) rises++;
      pt = trigger;
    end
    checks++; if (observed() !== model(5)) $display("FAIL ignore_value: got %h expected %h", observed(), model(5)); else passes++;
    checks++; if (rises !== 1) $display("FAIL ignore_pulses: got %0d expected 1", rises); else passes++;
    checks++; if (bn !== BUSY_LEN) $display("FAIL ignore_busy: got %0d expected %0d", bn, BUSY_LEN); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [IN_WIDTH-1:0] a, b;
    int rise_idx[$]; logic [12:0] rise_val[$];
    int lows = 0, guard = 0; logic pt = 1'b0;
    a = IN_WIDTH'($urandom_range(0, 1023));
    b = IN_WIDTH'($urandom_range(0, 1023));
    @(posedge clk); #1 start = 1'b1; bin = a;
    @(posedge clk); #1 bin = b;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (!busy) lows++;
      if (trigger && !pt) begin rise_idx.push_back(k); rise_val.push_back(observed()); end
      pt = trigger;
    end
    start = 1'b0;
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    checks++; if (rise_idx.size() !== 2) $display("FAIL b2b_pulses: got %0d expected 2", rise_idx.size()); else passes++;
    if (rise_idx.size() == 2) begin
      checks++; if (rise_idx[0] !== LAT || rise_idx[1] !== LAT + BUSY_LEN + 1) $display("FAIL b2b_spacing: got %0d,%0d expected %0d,%0d", rise_idx[0], rise_idx[1], LAT, LAT + BUSY_LEN + 1); else passes++;
      checks++; if (rise_val[0] !== model(a) || rise_val[1] !== model(b)) $display("FAIL b2b_values: got %h,%h expected %h,%h", rise_val[0], rise_val[1], model(a), model(b)); else passes++;
    end
    checks++; if (lows !== 1) $display("FAIL b2b_idle_gap: got %0d expected 1", lows); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_drain: got busy=%b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [12:0] r; int bn, tn, tf, trig_seen = 0; bit ec, lc;
    run_conv(10'd321, r, bn, tn, tf, ec, lc);
    @(posedge clk); #1 start = 1'b1; bin = 10'd876;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({busy, trigger, ovf} !== 3'b000) $display("FAIL midrst_ctrl: got %b expected 000", {busy, trigger, ovf}); else passes++;
    checks++; if ({num2, num1, num0} !== 12'h000) $display("FAIL midrst_num: got %h expected 000", {num2, num1, num0}); else passes++;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (trigger || busy) trig_seen++;
    end
    checks++; if (trig_seen !== 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", trig_seen); else passes++;
    run_conv(10'd42, r, bn, tn, tf, ec, lc);
    checks++; if (r !== model(42)) $display("FAIL midrst_restart: got %h expected %h", r, model(42)); else passes++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_zero();
    test_corners();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
